// File: rtl/conv_result_writeback.sv
// Convolution result write-back: bias add, optional ReLU, round/saturate
// requantization to 16 bits, result FIFO and feature-map RAM drain port.
module conv_result_writeback #(
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [31:0] out_pix,
  input  logic [13:0] result_addr,
  input  logic [31:0] bias,
  output logic        ack,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        busy,
  output logic [7:0]  sat_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int unsigned RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [33:0] RND =
    (SHIFT > 0) ? (34'sd1 <<< RS) : 34'sd0;

  typedef enum logic [1:0] {
    ARMED,
    ACK,
    WAIT_LOW
  } state_e;

  state_e state_q, state_d;

  logic               s1_valid_q;
  logic signed [33:0] s1_sum_q;
  logic [13:0]        s1_addr_q;
  logic               s2_valid_q;
  logic [15:0]        s2_data_q;
  logic [13:0]        s2_addr_q;

  logic [29:0]        fifo_q [FIFO_DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               mem_we_q;
  logic [13:0]        mem_addr_q;
  logic [15:0]        mem_din_q;
  logic [7:0]         sat_cnt_q;

  logic [CW+1:0]      used;
  logic               space, capture;
  logic               fifo_empty;
  logic               pop, bypass, push;
  logic signed [33:0] sum_in;
  logic signed [33:0] shifted, relu_v;
  logic               sat_hi, sat_lo;
  logic [15:0]        q16;

  // In-flight stage entries reserve FIFO slots so a capture never overflows.
  assign used = {2'b00, cnt_q}
              + {{(CW+1){1'b0}}, s1_valid_q}
              + {{(CW+1){1'b0}}, s2_valid_q};
  assign space   = used < (CW+2)'(FIFO_DEPTH);
  assign capture = (state_q == ARMED) && done && space;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARMED:    if (capture) state_d = ACK;
      ACK:      state_d = done ? WAIT_LOW : ARMED;
      WAIT_LOW: if (!done) state_d = ARMED;
      default:  state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARMED;
    else        state_q <= state_d;
  end

  assign ack = (state_q == ACK);

  assign sum_in = $signed({{2{out_pix[31]}}, out_pix})
                + $signed({{2{bias[31]}}, bias})
                + RND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= capture;
      if (capture) begin
        s1_sum_q  <= sum_in;
        s1_addr_q <= result_addr;
      end
    end
  end

  assign shifted = s1_sum_q >>> SHIFT;
  assign relu_v  = (RELU_EN && shifted < 34'sd0) ? 34'sd0 : shifted;
  assign sat_hi  = relu_v > 34'sd32767;
  assign sat_lo  = relu_v < -34'sd32768;

  always_comb begin
    q16 = relu_v[15:0];
    unique case (1'b1)
      sat_hi:  q16 = 16'h7FFF;
      sat_lo:  q16 = 16'h8000;
      default: q16 = relu_v[15:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_addr_q  <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= q16;
        s2_addr_q <= s1_addr_q;
        if ((sat_hi || sat_lo) && sat_cnt_q != 8'hFF)
          sat_cnt_q <= sat_cnt_q + 8'd1;
      end
    end
  end

  // An entry arriving at an empty FIFO may go straight to the RAM port.
  assign fifo_empty = (cnt_q == '0);
  assign pop    = mem_ready && !fifo_empty;
  assign bypass = mem_ready && fifo_empty && s2_valid_q;
  assign push   = s2_valid_q && !bypass;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {s2_addr_q, s2_data_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      mem_we_q <= pop || bypass;
      if (pop) begin
        mem_addr_q <= fifo_q[rptr_q][29:16];
        mem_din_q  <= fifo_q[rptr_q][15:0];
      end else if (bypass) begin
        mem_addr_q <= s2_addr_q;
        mem_din_q  <= s2_data_q;
      end
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign sat_cnt  = sat_cnt_q;
  assign busy     = s1_valid_q || s2_valid_q || !fifo_empty;

endmodule

// File: tb/tb_conv_result_writeback.sv
// Directed bench for conv_result_writeback: one ReLU instance and one
// pass-through instance driven from the same stimulus.
module tb_conv_result_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        done;
  logic [31:0] out_pix;
  logic [13:0] result_addr;
  logic [31:0] bias;
  logic        mem_ready;

  logic        ack, mem_we, busy;
  logic [13:0] mem_addr;
  logic [15:0] mem_din;
  logic [7:0]  sat_cnt;

  logic        n_ack, n_we, n_busy;
  logic [13:0] n_addr;
  logic [15:0] n_din;
  logic [7:0]  n_sat;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [29:0] wq[$];
  logic [29:0] nq[$];

  always #5 clk = ~clk;

  conv_result_writeback #(.SHIFT(8), .FIFO_DEPTH(4), .RELU_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .done(done), .out_pix(out_pix),
    .result_addr(result_addr), .bias(bias), .ack(ack),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .busy(busy), .sat_cnt(sat_cnt)
  );

  conv_result_writeback #(.SHIFT(8), .FIFO_DEPTH(4), .RELU_EN(1'b0)) u_nr (
    .clk(clk), .rst_n(rst_n), .done(done), .out_pix(out_pix),
    .result_addr(result_addr), .bias(bias), .ack(n_ack),
    .mem_ready(mem_ready), .mem_we(n_we), .mem_addr(n_addr),
    .mem_din(n_din), .busy(n_busy), .sat_cnt(n_sat)
  );

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_addr, mem_din});
    if (n_we)   nq.push_back({n_addr, n_din});
    if (ack)    ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pix, input logic [13:0] a);
    bit got;
    got = 1'b0;
    out_pix = pix;
    result_addr = a;
    done = 1'b1;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      if (ack) got = 1'b1;
    end
    done = 1'b0;
    if (!got) chk("offer_ack_timeout", 32'(got), 32'd1);
    tick();
  endtask

  initial begin
    int a0;
    bit got;
    rst_n = 1'b0;
    done = 1'b0;
    out_pix = '0;
    result_addr = '0;
    bias = 32'd24;
    mem_ready = 1'b1;
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr_din", {2'b0, mem_addr, mem_din}, 32'd0);
    chk("rst_busy_sat", {23'd0, busy, sat_cnt}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // basic path with exact latency
    out_pix = 32'd1000;
    result_addr = 14'h0123;
    done = 1'b1;
    tick();
    chk("basic_ack_c1", 32'(ack), 32'd1);
    chk("basic_busy", 32'(busy), 32'd1);
    done = 1'b0;
    tick();
    chk("basic_ack_c2", 32'(ack), 32'd0);
    chk("basic_we_c2", 32'(mem_we), 32'd0);
    tick();
    chk("basic_we_c3", 32'(mem_we), 32'd1);
    chk("basic_addr", 32'(mem_addr), 32'h0123);
    chk("basic_din", 32'(mem_din), 32'd4);
    tick();
    chk("basic_we_c4", 32'(mem_we), 32'd0);
    chk("basic_idle", 32'(busy), 32'd0);

    // ReLU and floor rounding
    bias = 32'd0;
    wq.delete();
    nq.delete();
    offer(-32'sd5000, 14'h0010);
    repeat (5) tick();
    chk("relu_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("relu_din", 32'(wq[0][15:0]), 32'd0);
    chk("norelu_nwr", 32'(nq.size()), 32'd1);
    if (nq.size() > 0) chk("norelu_din", 32'(nq[0][15:0]), 32'hFFEC);
    chk("relu_sat", 32'(sat_cnt), 32'd0);
    chk("norelu_sat", 32'(n_sat), 32'd0);

    // positive saturation, counter sticks at 255
    bias = 32'h7FFFFFFF;
    wq.delete();
    offer(32'h7FFFFFFF, 14'h0020);
    repeat (5) tick();
    if (wq.size() > 0) chk("sat_din", 32'(wq[0][15:0]), 32'h7FFF);
    else chk("sat_nwr", 32'(wq.size()), 32'd1);
    chk("sat_cnt1", 32'(sat_cnt), 32'd1);
    for (int i = 0; i < 299; i++) offer(32'h7FFFFFFF, 14'h0020);
    repeat (5) tick();
    chk("sat_cnt255", 32'(sat_cnt), 32'd255);
    chk("sat_cnt255_nr", 32'(n_sat), 32'd255);
    chk("sat_nwr300", 32'(wq.size()), 32'd300);

    // negative saturation on pass-through, clamp to 0 on ReLU
    bias = 32'h80000000;
    wq.delete();
    nq.delete();
    offer(32'h80000000, 14'h0030);
    repeat (5) tick();
    if (nq.size() > 0) chk("negsat_din", 32'(nq[0][15:0]), 32'h8000);
    else chk("negsat_nwr", 32'(nq.size()), 32'd1);
    if (wq.size() > 0) chk("negrelu_din", 32'(wq[0][15:0]), 32'd0);
    else chk("negrelu_nwr", 32'(wq.size()), 32'd1);

    // backpressure: four accepted, fifth stalls until drain
    bias = 32'd0;
    mem_ready = 1'b0;
    wq.delete();
    a0 = ack_cnt;
    for (int i = 0; i < 5; i++) begin
      out_pix = 32'((i + 1) * 256);
      result_addr = 14'(14'h100 + i);
      done = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        tick();
        if (ack) got = 1'b1;
      end
      if (i < 4) begin
        done = 1'b0;
        tick();
      end
    end
    chk("bp_acks4", 32'(ack_cnt - a0), 32'd4);
    chk("bp_nowrite", 32'(wq.size()), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick();
      if (ack) got = 1'b1;
    end
    done = 1'b0;
    chk("bp_fifth_ack", 32'(got), 32'd1);
    repeat (10) tick();
    chk("bp_acks5", 32'(ack_cnt - a0), 32'd5);
    chk("bp_nwr", 32'(wq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < wq.size())
        chk($sformatf("bp_wr%0d", i), 32'(wq[i]),
            32'({14'(14'h100 + i), 16'(i + 1)}));

    // handshake hygiene: long done gives one capture
    wq.delete();
    a0 = ack_cnt;
    out_pix = 32'd2560;
    result_addr = 14'h0200;
    done = 1'b1;
    repeat (10) tick();
    repeat (5) tick();
    chk("hold_acks", 32'(ack_cnt - a0), 32'd1);
    chk("hold_nwr", 32'(wq.size()), 32'd1);
    done = 1'b0;
    tick();
    result_addr = 14'h0201;
    done = 1'b1;
    repeat (3) tick();
    done = 1'b0;
    repeat (5) tick();
    chk("rearm_acks", 32'(ack_cnt - a0), 32'd2);
    chk("rearm_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() > 1) chk("rearm_addr", 32'(wq[1][29:16]), 32'h0201);

    // reset with buffered entries
    mem_ready = 1'b0;
    offer(32'd256, 14'h0300);
    offer(32'd512, 14'h0301);
    offer(32'd768, 14'h0302);
    repeat (3) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    wq.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {busy, ack, mem_we, mem_addr, mem_din}, 32'd0);
    chk("mid_rst_sat", 32'(sat_cnt), 32'd0);
    mem_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_nwr", 32'(wq.size()), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
